gpio_pad_sequencer: RTL and testbench
=====================================

# gpio_pad_sequencer

Controller that sequences power-up enables, run-time release and sleep/retention hold for a bank of sky130 GPIOv2 pads. It sits between the core power-management logic and the pad ring, driving each pad's ENABLE_H, ENABLE_VDDA_H, ENABLE_VSWITCH_H, ENABLE_VDDIO, ENABLE_INP_H and HOLD_H pins. It also runs a four-phase sleep handshake with the power controller.

## Interface

Parameters:

- NUM_PADS, 8: number of pads driven; width of hold_mask and hold_h.
- STEP_CYCLES, 16: clk cycles spent in each timed state; legal range 1..255.

Ports:

- clk  input  1  single clock.
- rst_n  input  1  reset; synchronous, active-low.
- pwr_good  input  1  pad supplies valid; already synchronous to clk.
- sleep_req  input  1  request to enter retention; four-phase with sleep_ack.
- hold_mask  input  NUM_PADS  1 = pad is frozen during sleep; sampled on sleep entry.
- enable_h  output  1  to ENABLE_H of all pads.
- enable_vddio  output  1  to ENABLE_VDDIO of all pads.
- enable_vdda_h  output  1  to ENABLE_VDDA_H of all pads.
- enable_vswitch_h  output  1  to ENABLE_VSWITCH_H of all pads.
- enable_inp_h  output  1  to ENABLE_INP_H of all pads.
- hold_h  output  NUM_PADS  per-pad HOLD_H; active-low (0 = pad state frozen).
- ready  output  1  pads are released and usable.
- sleep_ack  output  1  retention entered.
- fault_cnt  output  8  pwr_good loss count (see Configuration).
- state_o  output  3  current FSM state encoding, for debug.

## Operation

- All outputs are registered. Reset value of every output is 0, so hold_h = all 0 (all pads held). The FSM resets to OFF.
- States and encodings: OFF=0, EN_H=1, EN_VDDA=2, EN_INP=3, RUN=4, HOLD_ENTER=5, SLEEP=6, WAKE=7.
- OFF: all enables 0, hold_h all 0, ready 0, sleep_ack 0. Moves to EN_H when pwr_good=1.
- EN_H: enable_h=1, enable_vddio=1. This is a timed state.
- EN_VDDA: additionally enable_vdda_h=1 and enable_vswitch_h=1. Timed.
- EN_INP: additionally enable_inp_h=1. Timed.
- RUN: hold_h all 1, ready=1. Moves to HOLD_ENTER when sleep_req=1.
- HOLD_ENTER:
  - hold_h is set to ~hold_mask, using hold_mask as sampled on the entry edge.
  - ready=0. Timed.
  - Exits to SLEEP.
- SLEEP: sleep_ack=1 and hold_h is unchanged. Moves to WAKE when sleep_req=0.
- WAKE: sleep_ack stays 1 and hold_h is unchanged. Timed. Exits to RUN, where hold_h becomes all 1, sleep_ack 0 and ready 1.
- Enables stay asserted throughout HOLD_ENTER, SLEEP and WAKE. Only hold_h and the handshake outputs change.
- Timer:
  - Loaded with STEP_CYCLES-1 on entry to each timed state.
  - Decrements each cycle; the state advances on the edge where the timer is 0.
  - Width is 8 bits.
- pwr_good=0 in any state other than OFF: next edge goes to OFF and all outputs return to their reset values. This has priority over every other event, including simultaneous sleep_req.
- sleep_req dropped during HOLD_ENTER: entry still completes, SLEEP is held for exactly 1 cycle with sleep_ack=1, then the FSM goes to WAKE.
- sleep_req re-asserted during WAKE: ignored. The FSM completes to RUN, then re-enters HOLD_ENTER on the next edge if sleep_req is still 1.
- Changes to hold_mask outside the HOLD_ENTER entry edge have no effect.

## Timing

- pwr_good sampled 1 at edge k in OFF:
  - enable_h and enable_vddio are 1 after edge k.
  - enable_vdda_h and enable_vswitch_h are 1 after edge k+STEP_CYCLES.
  - enable_inp_h is 1 after edge k+2·STEP_CYCLES.
  - ready and hold_h all 1 after edge k+3·STEP_CYCLES.
- sleep_req sampled 1 at edge k in RUN: hold_h and ready change after edge k. sleep_ack=1 after edge k+STEP_CYCLES.
- sleep_req sampled 0 at edge k in SLEEP: hold_h all 1, sleep_ack 0 and ready 1 after edge k+STEP_CYCLES.
- pwr_good loss: 1-cycle latency to all-zero outputs.
- rst_n=0 mid-sequence: same 1-cycle latency and result as pwr_good loss, and the timer is cleared.

## Configuration

- GPIO_PAD_SEQ_FAULT_CNT_EN defined:
  - fault_cnt is an 8-bit saturating counter (stops at 255).
  - Increments on every FSM transition into OFF caused by pwr_good=0.
  - Cleared only by rst_n.
- Not defined: fault_cnt is constant 0 and no counter logic is built.

## Test plan

- Power-up, STEP_CYCLES=16: raise pwr_good at edge 0 -> enable_h at 1, enable_vdda_h at 17, enable_inp_h at 33, ready=1 and hold_h=8'hFF at 49.
- Sleep with hold_mask=8'h0F in RUN: assert sleep_req -> hold_h=8'hF0 and ready=0 next cycle, sleep_ack=1 16 cycles later. Drop sleep_req -> hold_h=8'hFF, sleep_ack=0, ready=1 16 cycles after that.
- Early release: drop sleep_req 5 cycles into HOLD_ENTER -> sleep_ack pulses high for exactly 1 cycle, then ready=1 16 cycles later.
- pwr_good drops in EN_VDDA, with sleep_req=1 in the same cycle -> next cycle all enables 0, hold_h=0, state_o=0. Power-up restarts from EN_H when pwr_good returns.
- With GPIO_PAD_SEQ_FAULT_CNT_EN: 300 pwr_good drops, each from RUN -> fault_cnt=255. Apply rst_n=0 for 1 cycle -> fault_cnt=0 and all outputs 0. Without the macro, fault_cnt stays 0 throughout.

Source files
------------

// File: rtl/gpio_pad_sequencer.sv
// Power-up / sleep-retention sequencer for a bank of sky130 GPIOv2 pads.
// Optional pwr_good loss counter enabled by defining GPIO_PAD_SEQ_FAULT_CNT_EN.
module gpio_pad_sequencer #(
  parameter int unsigned NUM_PADS    = 8,
  parameter int unsigned STEP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwr_good,
  input  logic                sleep_req,
  input  logic [NUM_PADS-1:0] hold_mask,
  output logic                enable_h,
  output logic                enable_vddio,
  output logic                enable_vdda_h,
  output logic                enable_vswitch_h,
  output logic                enable_inp_h,
  output logic [NUM_PADS-1:0] hold_h,
  output logic                ready,
  output logic                sleep_ack,
  output logic [7:0]          fault_cnt,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    EN_H       = 3'd1,
    EN_VDDA    = 3'd2,
    EN_INP     = 3'd3,
    RUN        = 3'd4,
    HOLD_ENTER = 3'd5,
    SLEEP      = 3'd6,
    WAKE       = 3'd7
  } state_t;

  localparam logic [7:0] TLOAD = 8'(STEP_CYCLES - 1);

  state_t              state, state_nxt;
  logic [7:0]          timer, timer_nxt;
  logic                tdone;
  logic                en_h_nxt, en_vdda_nxt, en_inp_nxt, ready_nxt, ack_nxt;
  logic [NUM_PADS-1:0] hold_nxt;

  assign tdone   = (timer == 8'd0);
  assign state_o = state;

  always_comb begin
    state_nxt = state;
    unique case (state)
      OFF:        if (pwr_good)   state_nxt = EN_H;
      EN_H:       if (tdone)      state_nxt = EN_VDDA;
      EN_VDDA:    if (tdone)      state_nxt = EN_INP;
      EN_INP:     if (tdone)      state_nxt = RUN;
      RUN:        if (sleep_req)  state_nxt = HOLD_ENTER;
      HOLD_ENTER: if (tdone)      state_nxt = SLEEP;
      SLEEP:      if (!sleep_req) state_nxt = WAKE;
      WAKE:       if (tdone)      state_nxt = RUN;
      default:                    state_nxt = OFF;
    endcase
    // Supply loss overrides every other event, including sleep_req.
    if (state != OFF && !pwr_good) state_nxt = OFF;
  end

  always_comb begin
    timer_nxt = '0;
    if (state_nxt inside {EN_H, EN_VDDA, EN_INP, HOLD_ENTER, WAKE}) begin
      if (state_nxt != state) timer_nxt = TLOAD;
      else                    timer_nxt = timer - 8'd1;
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    en_h_nxt    = (state_nxt != OFF);
    en_vdda_nxt = !(state_nxt inside {OFF, EN_H});
    en_inp_nxt  = !(state_nxt inside {OFF, EN_H, EN_VDDA});
    ready_nxt   = (state_nxt == RUN);
    ack_nxt     = (state_nxt inside {SLEEP, WAKE});
    hold_nxt    = '0;
    unique case (state_nxt)
      RUN:        hold_nxt = '1;
      HOLD_ENTER: hold_nxt = (state == RUN) ? ~hold_mask : hold_h;
      SLEEP,
      WAKE:       hold_nxt = hold_h;
      default:    hold_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= OFF;
      timer            <= '0;
      enable_h         <= 1'b0;
      enable_vddio     <= 1'b0;
      enable_vdda_h    <= 1'b0;
      enable_vswitch_h <= 1'b0;
      enable_inp_h     <= 1'b0;
      hold_h           <= '0;
      ready            <= 1'b0;
      sleep_ack        <= 1'b0;
    end else begin
      state            <= state_nxt;
      timer            <= timer_nxt;
      enable_h         <= en_h_nxt;
      enable_vddio     <= en_h_nxt;
      enable_vdda_h    <= en_vdda_nxt;
      enable_vswitch_h <= en_vdda_nxt;
      enable_inp_h     <= en_inp_nxt;
      hold_h           <= hold_nxt;
      ready            <= ready_nxt;
      sleep_ack        <= ack_nxt;
    end
  end

`ifdef GPIO_PAD_SEQ_FAULT_CNT_EN
  logic [7:0] fault_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_q <= '0;
    end else if (state != OFF && !pwr_good && fault_q != 8'hFF) begin
      fault_q <= fault_q + 8'd1;
    end
  end

  assign fault_cnt = fault_q;
`else
  assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_gpio_pad_sequencer.sv
// Scoreboard bench for gpio_pad_sequencer: a phase/elapsed-time reference model
// predicts every cycle's outputs, a monitor compares them after each edge.
module tb_gpio_pad_sequencer;
  localparam int unsigned NP = 8;
  localparam int unsigned SC = 16;

  logic          clk = 1'b0;
  logic          rst_n, pwr_good, sleep_req;
  logic [NP-1:0] hold_mask;
  logic          enable_h, enable_vddio, enable_vdda_h, enable_vswitch_h, enable_inp_h;
  logic [NP-1:0] hold_h;
  logic          ready, sleep_ack;
  logic [7:0]    fault_cnt;
  logic [2:0]    state_o;

  gpio_pad_sequencer #(.NUM_PADS(NP), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_good(pwr_good), .sleep_req(sleep_req),
    .hold_mask(hold_mask), .enable_h(enable_h), .enable_vddio(enable_vddio),
    .enable_vdda_h(enable_vdda_h), .enable_vswitch_h(enable_vswitch_h),
    .enable_inp_h(enable_inp_h), .hold_h(hold_h), .ready(ready),
    .sleep_ack(sleep_ack), .fault_cnt(fault_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef logic [25:0] obs_t;
  obs_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: phase number (spec numbering), cycles spent in phase, captured hold.
  int         phase   = 0;
  int         elapsed = 0;
  int         faults  = 0;
  logic [7:0] cap     = '0;

  function automatic obs_t expected_obs();
    logic [7:0] h;
    logic [7:0] f;
    h = (phase < 4) ? 8'h00 : (phase == 4) ? 8'hFF : cap;
`ifdef GPIO_PAD_SEQ_FAULT_CNT_EN
    f = 8'(faults);
`else
    f = 8'h00;
`endif
    return {phase >= 1, phase >= 1, phase >= 2, phase >= 2, phase >= 3,
            h, phase == 4, phase >= 6, f, 3'(phase)};
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      phase = 0; elapsed = 0; cap = '0; faults = 0;
    end else if (phase != 0 && !pwr_good) begin
      phase = 0; elapsed = 0;
      if (faults < 255) faults++;
    end else begin
      case (phase)
        0: if (pwr_good) begin phase = 1; elapsed = 0; end
        1, 2, 3, 5, 7: begin
          elapsed++;
          if (elapsed == SC) begin
            phase = (phase == 7) ? 4 : phase + 1;
            elapsed = 0;
          end
        end
        4: if (sleep_req) begin phase = 5; elapsed = 0; cap = ~hold_mask; end
        6: if (!sleep_req) begin phase = 7; elapsed = 0; end
        default: phase = 0;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic pg, input logic sr, input logic [7:0] hm);
    @(negedge clk);
    rst_n = r; pwr_good = pg; sleep_req = sr; hold_mask = hm;
    model_edge();
    q.push_back(expected_obs());
    @(posedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(rst_n, pwr_good, sleep_req, hold_mask);
  endtask

  always @(posedge clk) begin
    obs_t exp_v, act_v;
    #1;
    if (q.size() > 0) begin
      exp_v = q.pop_front();
      act_v = {enable_h, enable_vddio, enable_vdda_h, enable_vswitch_h, enable_inp_h,
               hold_h, ready, sleep_ack, fault_cnt, state_o};
      checks++;
      if (act_v !== exp_v)
        $display("FAIL outputs t=%0t actual=%h required=%h (state %0d vs %0d, hold %h vs %h, fault %0d vs %0d)",
                 $time, act_v, exp_v, act_v[2:0], exp_v[2:0], act_v[20:13], exp_v[20:13],
                 act_v[10:3], exp_v[10:3]);
      else
        passed++;
    end
  end

  initial begin
    rst_n = 1'b0; pwr_good = 1'b0; sleep_req = 1'b0; hold_mask = 8'h00;
    step(0, 0, 0, 8'h00);
    #2;
    checks++;
    if ({enable_h, enable_vddio, enable_vdda_h, enable_vswitch_h, enable_inp_h,
         hold_h, ready, sleep_ack, fault_cnt, state_o} !== '0)
      $display("FAIL reset state t=%0t state=%0d hold=%h ready=%b ack=%b fault=%0d",
               $time, state_o, hold_h, ready, sleep_ack, fault_cnt);
    else
      passed++;
    step(0, 1, 1, 8'hAA);
    step(1, 0, 0, 8'h00);
    // Power-up ramp to RUN.
    step(1, 1, 0, 8'h00);
    run(55);
    // Sleep with mask 0F; mask changes after entry must not matter.
    step(1, 1, 1, 8'h0F);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 8'($urandom));
    step(1, 1, 0, 8'h33);
    run(20);
    // Early release five cycles into HOLD_ENTER.
    step(1, 1, 1, 8'h5A);
    run(4);
    step(1, 1, 0, 8'h5A);
    run(25);
    // Re-request during WAKE.
    step(1, 1, 1, 8'hC3);
    run(18);
    step(1, 1, 0, 8'hC3);
    run(5);
    step(1, 1, 1, 8'h3C);
    run(20);
    step(1, 1, 0, 8'h3C);
    run(20);
    // Supply loss in EN_VDDA with a simultaneous sleep request.
    step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    run(20);
    step(1, 0, 1, 8'hFF);
    step(1, 0, 1, 8'hFF);
    step(1, 1, 0, 8'h00);
    run(55);
    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic r, pg, sr;
      r  = ($urandom_range(499) != 0);
      pg = ($urandom_range(199) != 0);
      sr = ($urandom_range(19) == 0) ? ~sleep_req : sleep_req;
      step(r, pg, sr, 8'($urandom));
    end
    // Repeated supply loss from RUN to saturate the fault counter.
    step(0, 1, 0, 8'h00);
    for (int d = 0; d < 300; d++) begin
      for (int t = 0; t < 200 && phase != 4; t++) step(1, 1, 0, 8'($urandom));
      checks++;
      if (phase != 4)
        $display("FAIL wait for RUN expired t=%0t drop=%0d phase=%0d state=%0d",
                 $time, d, phase, state_o);
      else
        passed++;
      step(1, 0, 0, 8'($urandom));
    end
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    run(3);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
